// File: rtl/multi_mode_counter.sv
// NUM_CH independent WIDTH-bit up/down/ping-pong/hold counters with load and tc.
// Define MULTI_MODE_COUNTER_CASCADE_EN to chain channel wraps into one wide counter.
module multi_mode_counter #(
   parameter int WIDTH  = 4,
   parameter int NUM_CH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       en,
   input  logic [2*NUM_CH-1:0]     mode,
   input  logic [WIDTH*NUM_CH-1:0] limit,
   input  logic [NUM_CH-1:0]       load,
   input  logic [WIDTH*NUM_CH-1:0] load_val,
   output logic [WIDTH*NUM_CH-1:0] count,
   output logic [NUM_CH-1:0]       tc,
   output logic [NUM_CH-1:0]       dir
);

   typedef enum logic [1:0] {
      M_UP   = 2'b00,
      M_DOWN = 2'b01,
      M_PING = 2'b10,
      M_HOLD = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] lim;
      logic [WIDTH-1:0] lv;
      logic [WIDTH-1:0] nxt;
      logic             nxt_dir;
      logic             wrap;
      logic             ce;
      logic             run;
      logic             carry;
      mode_e            m;

      logic [WIDTH-1:0] cnt_q;
      logic             tc_q;
      logic             dir_q;

      assign cur = cnt_q;
      assign lim = limit[i*WIDTH +: WIDTH];
      assign lv  = load_val[i*WIDTH +: WIDTH];
      assign m   = mode_e'(mode[2*i +: 2]);

`ifdef MULTI_MODE_COUNTER_CASCADE_EN
      // Upper channels only step on the edge where the channel below wraps.
      if (i == 0) begin : g_first
         assign ce = en[0];
      end else begin : g_next
         assign ce = en[i] & g_ch[i-1].carry;
      end
`else
      assign ce = en[i];
`endif

      assign run   = ce & (m != M_HOLD);
      assign carry = run & ~load[i] & wrap;

      always_comb begin
         nxt     = cur;
         nxt_dir = 1'b0;
         wrap    = 1'b0;
         unique case (m)
            M_UP: begin
               if (cur >= lim) begin
                  nxt  = ZERO;
                  wrap = 1'b1;
               end else begin
                  nxt = cur + ONE;
               end
            end
            M_DOWN: begin
               if (cur == ZERO) begin
                  nxt  = lim;
                  wrap = 1'b1;
               end else if (cur > lim) begin
                  nxt = lim;
               end else begin
                  nxt = cur - ONE;
               end
            end
            M_PING: begin
               if (!dir_q) begin
                  if (cur >= lim) begin
                     nxt     = (lim == ZERO) ? ZERO : lim - ONE;
                     nxt_dir = 1'b1;
                     wrap    = 1'b1;
                  end else begin
                     nxt = cur + ONE;
                  end
               end else begin
                  nxt_dir = 1'b1;
                  if (cur == ZERO) begin
                     nxt     = (lim == ZERO) ? ZERO : ONE;
                     nxt_dir = 1'b0;
                     wrap    = 1'b1;
                  end else if (cur > lim) begin
                     nxt = lim;
                  end else begin
                     nxt = cur - ONE;
                  end
               end
            end
            M_HOLD: begin
               nxt     = cur;
               nxt_dir = dir_q;
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q <= ZERO;
            tc_q  <= 1'b0;
            dir_q <= 1'b0;
         end else if (load[i]) begin
            cnt_q <= (lv > lim) ? lim : lv;
            tc_q  <= 1'b0;
            dir_q <= 1'b0;
         end else if (run) begin
            cnt_q <= nxt;
            tc_q  <= wrap;
            dir_q <= nxt_dir;
         end else begin
            tc_q <= 1'b0;
         end
      end

      assign count[i*WIDTH +: WIDTH] = cnt_q;
      assign tc[i]  = tc_q;
      assign dir[i] = dir_q;
   end

endmodule

// File: doc/multi_mode_counter.md
Name: multi_mode_counter

Overview:
- Parametrised successor to the fixed two-channel, 4-bit free-running counter block.
- Provides NUM_CH independent WIDTH-bit counters, each with:
  - a runtime terminal limit;
  - up, down, ping-pong or hold mode;
  - synchronous load and per-channel enable;
  - a terminal-count pulse.
- Used as a general timebase/sequencer inside the basic-blocks library; channels can optionally be cascaded into one wide counter.

Parameters:
- WIDTH, 4, bit width of each channel counter.
- NUM_CH, 2, number of counter channels (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  NUM_CH  per-channel count enable; bit i is channel i.
- mode  input  2*NUM_CH  per-channel mode; bits [2i+1:2i] belong to channel i:
  - 00 = up;
  - 01 = down;
  - 10 = ping-pong;
  - 11 = hold.
- limit  input  WIDTH*NUM_CH  per-channel terminal value; counting range is 0..limit inclusive.
- load  input  NUM_CH  per-channel synchronous load strobe.
- load_val  input  WIDTH*NUM_CH  per-channel load value.
- count  output  WIDTH*NUM_CH  registered per-channel count.
- tc  output  NUM_CH  registered one-cycle terminal-count pulse.
- dir  output  NUM_CH  registered ping-pong direction (0 = up, 1 = down).

Behaviour:
- Reset:
  - One clock, synchronous active-high reset named reset; clock port named clk.
  - On reset: count = 0, tc = 0, dir = 0 for all channels.
- Priority per channel, evaluated each rising edge: reset > load > enabled count > hold.
- Load:
  - count <= min(load_val, limit); dir <= 0; tc <= 0.
  - Takes effect even when en = 0.
- When en = 0, or mode = 11, or the cascade gate is closed: count and dir hold; tc <= 0.
- Up (00):
  - If count >= limit: count <= 0, tc <= 1.
  - Else: count <= count + 1, tc <= 0.
- Down (01):
  - If count == 0: count <= limit, tc <= 1.
  - Else if count > limit: count <= limit, tc <= 0.
  - Else: count <= count - 1, tc <= 0.
- Ping-pong (10), sequence 0,1,..,limit,limit-1,..,0,1,...:
  - dir = 0:
    - If count >= limit: count <= limit-1, dir <= 1, tc <= 1. Exception: when limit = 0, count <= 0.
    - Else: count + 1.
  - dir = 1:
    - If count == 0: count <= 1, dir <= 0, tc <= 1. Exception: when limit = 0, count <= 0.
    - Else if count > limit: count <= limit.
    - Else: count - 1.
- Mode other than 10: dir <= 0 on every enabled cycle.
- Arithmetic: unsigned, WIDTH bits, no overflow possible given the rules above; limit = 2^WIDTH-1 gives full-range wrap.
- limit = 0: count stays 0; tc = 1 on every enabled cycle in every counting mode.
- Timing of changes:
  - Mode and limit changes take effect on the next enabled edge; no flush.
  - Latency: count and tc reflect an edge's decision one cycle after the inputs are sampled (registered outputs, no combinational input->output path).
- Reset asserted mid-count or together with load/en: reset wins that cycle; counting resumes from 0 on the first edge with reset low.

Optional Feature:
- Macro: MULTI_MODE_COUNTER_CASCADE_EN.
- Defined:
  - Channel i>0 effective enable = en[i] & carry[i-1].
  - carry[i-1] is the combinational wrap condition of channel i-1 on this edge: its effective enable is high, it is not loading, and its next-state logic selects a tc = 1 transition.
  - Channel 0 uses en[0] directly.
  - The carry chain ripples combinationally, so all channels in up mode form one NUM_CH*WIDTH-bit counter.
- Not defined: channels are fully independent; no carry logic is synthesised.

Test Plan:
- Reset/idle: reset = 1 for 2 cycles with en = 11 -> count = 0, tc = 0, dir = 0. Release reset, ch0 up, limit = 15 -> ch0 counts 1,2,..,15,0; tc high on exactly the cycle count shows 0 after 15.
- Down with limit: ch1 down, limit = 5 from count 0 -> next count 5 with tc = 1, then 4,3,2,1,0,5; tc pulses only on the 0->5 cycles.
- Ping-pong: ch0 mode 10, limit = 3 -> 1,2,3,2,1,0,1; dir rises on the cycle count goes 3->2 and falls on 0->1; tc pulses on both turnarounds.
- Load, clamp and priority:
  - load = 1, load_val = 12, limit = 9 -> count = 9.
  - load with en = 0 still loads.
  - reset with load same cycle -> count = 0.
- Boundaries: limit = 0 in up mode -> count stays 0, tc = 1 every enabled cycle. Lower limit from 15 to 4 while count = 10 in up mode -> next count 0 with tc = 1. Hold mode (11) -> count frozen, tc = 0.
- With MULTI_MODE_COUNTER_CASCADE_EN, both channels up, limit = 15, en = 11 -> ch1 increments only when ch0 wraps 15->0. After 256 cycles both read 0 and ch1 tc = 1 once. Without the macro, ch1 increments every cycle.
